alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational MainALU (16-bit A/B, 3-bit ALUControl, 32-bit Result, Overflow)
//   between NUM_REQ requesters, e.g. the EX stage and the address/branch unit. Arbitrates,
//   registers the winner's operands onto the ALU, captures Result/Overflow one cycle later
//   and returns them to the winner over a valid/ready response handshake.
//   The block does not decode or modify ALUControl; every code 000-111 passes through unchanged.
// PARAMETERS
//   NUM_REQ  2   number of requesters (2..4)
//   DATA_W   16  operand width, matches MainALU A/B
//   RES_W    32  result width, matches MainALU Result
// PORTS
//   clk           in   1                 system clock, rising edge
//   rst_n         in   1                 asynchronous active-low reset
//   req_valid     in   NUM_REQ           per-requester operation request
//   req_ready     out  NUM_REQ           one-hot accept; a transfer occurs when valid&ready
//   req_a         in   NUM_REQ*DATA_W    packed operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b         in   NUM_REQ*DATA_W    packed operand B, same packing
//   req_op        in   NUM_REQ*3         packed ALUControl codes
//   rsp_valid     out  NUM_REQ           one-hot: result available for requester i
//   rsp_ready     in   NUM_REQ           requester i consumes the response
//   rsp_result    out  RES_W             captured Result, shared by all requesters
//   rsp_overflow  out  1                 captured Overflow
//   alu_a, alu_b  out  DATA_W            registered operands driven to MainALU
//   alu_ctrl      out  3                 registered ALUControl driven to MainALU
//   alu_result    in   RES_W             MainALU Result
//   alu_overflow  in   1                 MainALU Overflow
//   busy          out  1                 high in EXEC and RESP
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; req_ready=0; rsp_valid=0; rsp_result=0; rsp_overflow=0;
//     alu_a=alu_b=0; alu_ctrl=3'b000; busy=0; RR pointer=0. Clear takes effect immediately;
//     any in-flight operation is dropped and no response is produced.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//     IDLE: req_ready is combinational and one-hot on the arbitration winner among valid
//       requesters (all zero if none valid). On a transfer: latch a/b/op into alu_*,
//       latch the winner id, advance the RR pointer to winner+1 (mod NUM_REQ), go to EXEC.
//     EXEC: exactly one cycle. Capture alu_result/alu_overflow into rsp_*,
//       set rsp_valid[id]=1, go to RESP.
//     RESP: hold rsp_valid[id], rsp_result and rsp_overflow stable until rsp_ready[id]=1.
//       Then clear rsp_valid and go to IDLE. rsp_ready of non-owners is ignored.
//   req_ready is 0 outside IDLE. An accepted requester receives no further grant until its
//     response completes.
//   Latency: accept edge -> rsp_valid high after 2 clk edges.
//     Minimum issue interval: 3 cycles (rsp_ready held high).
//   Arbitration: round-robin. The search starts at the RR pointer; the first valid index wins.
//     Ties on simultaneous requests resolve by pointer order.
//   alu_* hold their last values between operations; MainALU inputs change only on accept.
//   Requesters hold req_a/b/op stable while req_valid=1 and req_ready=0.
//     Deasserting req_valid before the grant withdraws the request legally.
//   No width conversion: alu_result flows to rsp_result bit-for-bit.
// CONFIGURATION
//   ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; RR pointer is removed
//     (no flops).
//   Not defined (default): round-robin as described above.
// TESTING (bench instantiates MainALU behind this block, NUM_REQ=2)
//   1. Single request: r0 op=000 A=ffff B=ffff -> accept, 2 cycles later rsp_valid=01,
//      result=ALU sum of ffff+ffff, overflow matches the direct-ALU value.
//   2. Simultaneous: r0 sub 0010-0001 and r1 and 0f0f&0fff, both valid at cycle 0 ->
//      r0 served first (ptr=0) with result 000f, then r1 with result 0f0f; alternation repeats.
//   3. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stable,
//      req_ready=00, busy=1; release -> IDLE on the next edge.
//   4. Reset mid-op: assert rst_n=0 during EXEC -> outputs go to reset values immediately,
//      no rsp_valid after release.
//   5. Fixed priority (ALU_ARB_FIXED_PRIO_EN): r0 and r1 continuously valid ->
//      r0 always wins and r1 starves.
//   6. Op passthrough: codes 010, 011, 101 on r1 -> alu_ctrl equals req_op; results match
//      the direct MainALU outputs.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : alu_share_arbiter_if                                         |
// | Description : Requester-side bundle for alu_share_arbiter. Carries the     |
// |               per-requester request handshake with packed operands and the |
// |               response handshake with the shared captured result.          |
// |   req_valid  [NUM_REQ]          requester -> arbiter, operation request    |
// |   req_ready  [NUM_REQ]          arbiter -> requester, one-hot accept       |
// |   req_a/b    [NUM_REQ*DATA_W]   packed operands, slot i at [i*DATA_W +:]   |
// |   req_op     [NUM_REQ*3]        packed ALUControl codes                    |
// |   rsp_valid  [NUM_REQ]          arbiter -> requester, one-hot result flag  |
// |   rsp_ready  [NUM_REQ]          requester -> arbiter, response consumed    |
// |   rsp_result [RES_W]            captured Result, shared by all requesters  |
// |   rsp_overflow                  captured Overflow                          |
// |   master modport = requester side, slave modport = arbiter side.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*3-1:0]      req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [RES_W-1:0]          rsp_result;
    logic                      rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : alu_share_arbiter                                            |
// | Description : Shares one combinational MainALU between NUM_REQ requesters. |
// |               IDLE arbitrates and registers the winner's operands onto the |
// |               ALU, EXEC captures Result/Overflow, RESP holds the response  |
// |               until the owner takes it. ALUControl passes through as-is.   |
// | Ports       : clk, rst_n (async active-low)                                |
// |               bus          alu_share_arbiter_if.slave (req/rsp handshakes) |
// |               alu_a/alu_b  registered operands to MainALU                  |
// |               alu_ctrl     registered ALUControl to MainALU                |
// |               alu_result / alu_overflow  MainALU outputs                   |
// |               busy         high in EXEC and RESP                           |
// | Config      : ALU_ARB_FIXED_PRIO_EN defined -> fixed priority (lowest      |
// |               index wins, no round-robin pointer); default round-robin.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    alu_share_arbiter_if.slave     bus,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [2:0]             alu_ctrl,
    input  wire logic [RES_W-1:0]  alu_result,
    input  wire logic              alu_overflow,
    output logic                   busy
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [2:0]         alu_ctrl_q, alu_ctrl_d;
    logic [RES_W-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_overflow_q, rsp_overflow_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [IDW-1:0]     w_win_id;
    logic               w_found;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_busy;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid index is written last.
    always_comb begin
        w_win_id = '0;
        w_found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                w_win_id = IDW'(k);
                w_found  = 1'b1;
            end
        end
    end
`else
    localparam logic [IDW:0] c_NREQ = (IDW + 1)'(NUM_REQ);

    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDW-1:0]       w_off;
    logic [IDW:0]         w_sum;
    logic [IDW:0]         w_next_ptr;

    // Doubling the valid vector and slicing at the pointer gives the
    // requests rotated so bit 0 is the requester the search starts from.
    always_comb begin
        w_dbl   = {bus.req_valid, bus.req_valid};
        w_rot   = w_dbl[rr_ptr_q +: NUM_REQ];
        w_off   = '0;
        w_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off   = IDW'(k);
                w_found = 1'b1;
            end
        end
        w_sum = {1'b0, rr_ptr_q} + {1'b0, w_off};
        if (w_sum >= c_NREQ) begin
            w_sum = w_sum - c_NREQ;
        end
        w_win_id = w_sum[IDW-1:0];

        w_next_ptr = {1'b0, w_win_id} + (IDW + 1)'(1);
        if (w_next_ptr >= c_NREQ) begin
            w_next_ptr = '0;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_xfer) begin
            rr_ptr_d = w_next_ptr[IDW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign w_grant = w_found ? (NUM_REQ'(1) << w_win_id) : '0;
    assign w_xfer  = (state_q == c_ST_IDLE) && w_found;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_xfer) state_d = c_ST_EXEC;
            c_ST_EXEC: state_d = c_ST_RESP;
            c_ST_RESP: if (bus.rsp_ready[id_q]) state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_req_ready = '0;
        w_busy      = 1'b0;
        case (state_q)
            c_ST_IDLE: w_req_ready = w_grant;
            c_ST_EXEC: w_busy = 1'b1;
            c_ST_RESP: w_busy = 1'b1;
            default:   w_busy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch on accept, result capture in EXEC
    // ------------------------------------------------------------------
    always_comb begin
        id_d           = id_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_ctrl_d     = alu_ctrl_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_valid_d    = rsp_valid_q;

        case (state_q)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    id_d = w_win_id;
                    // Grant is one-hot, so at most one slot is selected.
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_grant[i]) begin
                            alu_a_d    = bus.req_a[i*DATA_W +: DATA_W];
                            alu_b_d    = bus.req_b[i*DATA_W +: DATA_W];
                            alu_ctrl_d = bus.req_op[i*3 +: 3];
                        end
                    end
                end
            end
            c_ST_EXEC: begin
                rsp_result_d   = alu_result;
                rsp_overflow_d = alu_overflow;
                rsp_valid_d    = NUM_REQ'(1) << id_q;
            end
            c_ST_RESP: begin
                if (bus.rsp_ready[id_q]) begin
                    rsp_valid_d = '0;
                end
            end
            default: rsp_valid_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q           <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= 3'b000;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_valid_q    <= '0;
        end else begin
            id_q           <= id_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_ctrl_q     <= alu_ctrl_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_valid_q    <= rsp_valid_d;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_ctrl         = alu_ctrl_q;
    assign busy             = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_share_arbiter                                         |
// | Description : Directed self-checking bench for alu_share_arbiter with a    |
// |               behavioural MainALU behind it (NUM_REQ=2). Honours           |
// |               ALU_ARB_FIXED_PRIO_EN when choosing expected winners.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 16;
    localparam int RES_W   = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [RES_W-1:0]  alu_result;
    logic              alu_overflow;
    logic              busy;

    alu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .RES_W   (RES_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .busy         (busy)
    );

    // Behavioural MainALU: overflow is signed 16-bit overflow for add/sub.
    logic [15:0] t16;
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        t16          = '0;
        case (alu_ctrl)
            3'b000: begin
                alu_result   = {16'h0, alu_a} + {16'h0, alu_b};
                t16          = alu_a + alu_b;
                alu_overflow = (alu_a[15] == alu_b[15]) && (t16[15] != alu_a[15]);
            end
            3'b001: begin
                t16          = alu_a - alu_b;
                alu_result   = {16'h0, t16};
                alu_overflow = (alu_a[15] != alu_b[15]) && (t16[15] != alu_a[15]);
            end
            3'b010:  alu_result = {16'h0, alu_a & alu_b};
            3'b011:  alu_result = {16'h0, alu_a | alu_b};
            3'b100:  alu_result = {16'h0, alu_a ^ alu_b};
            3'b101:  alu_result = {31'h0, ($signed(alu_a) < $signed(alu_b))};
            3'b110:  alu_result = {16'h0, ~(alu_a | alu_b)};
            default: alu_result = {31'h0, (alu_a < alu_b)};
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on requester id, rsp_ready raised once valid.
    task automatic run_single(input int id, input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] op, input logic [31:0] eres,
                              input logic eov, input string tag);
        bus.req_a[id*16 +: 16] = a;
        bus.req_b[id*16 +: 16] = b;
        bus.req_op[id*3 +: 3]  = op;
        bus.req_valid          = 2'(1 << id);
        bus.rsp_ready          = 2'b00;
        #1;
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << id));
        tick();
        bus.req_valid = 2'b00;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rdy_off"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
        chk({tag, "_alu_b"}, 32'(alu_b), 32'(b));
        chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(op));
        chk({tag, "_no_rsp_yet"}, 32'(bus.rsp_valid), 32'd0);
        tick();
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << id));
        chk({tag, "_result"}, bus.rsp_result, eres);
        chk({tag, "_ovf"}, 32'(bus.rsp_overflow), 32'(eov));
        bus.rsp_ready = 2'(1 << id);
        tick();
        bus.rsp_ready = 2'b00;
        chk({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_alu_hold"}, 32'(alu_a), 32'(a));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_id;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '0;

        // Reset values
        #2;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_result", bus.rsp_result, 32'd0);
        chk("rst_ovf", 32'(bus.rsp_overflow), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single requests: add without and with signed overflow
        run_single(0, 16'hffff, 16'hffff, 3'b000, 32'h0001_fffe, 1'b0, "t1_add");
        run_single(1, 16'h7fff, 16'h0001, 3'b000, 32'h0000_8000, 1'b1, "t1_ovf");

        // Simultaneous requests, both held valid, rsp_ready held high
        bus.req_a[15:0]  = 16'h0010; bus.req_b[15:0]  = 16'h0001; bus.req_op[2:0] = 3'b001;
        bus.req_a[31:16] = 16'h0f0f; bus.req_b[31:16] = 16'h0fff; bus.req_op[5:3] = 3'b010;
        bus.req_valid    = 2'b11;
        bus.rsp_ready    = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = n % 2;
`endif
            chk("t2_grant", 32'(bus.req_ready), 32'(1 << exp_id));
            tick();
            chk("t2_busy", 32'(busy), 32'd1);
            chk("t2_ctrl", 32'(alu_ctrl), (exp_id == 1) ? 32'd2 : 32'd1);
            tick();
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'(1 << exp_id));
            chk("t2_result", bus.rsp_result, (exp_id == 1) ? 32'h0000_0f0f : 32'h0000_000f);
            tick();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;

        // Backpressure on r1 with r0 waiting and a non-owner rsp_ready
        bus.req_a[31:16] = 16'h0003; bus.req_b[31:16] = 16'h0005; bus.req_op[5:3] = 3'b011;
        bus.req_valid    = 2'b10;
        #1;
        chk("t3_grant", 32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 2'b01;
        tick();
        bus.rsp_ready = 2'b01;
        for (int n = 0; n < 5; n++) begin
            chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd2);
            chk("t3_hold_result", bus.rsp_result, 32'h0000_0007);
            chk("t3_hold_rdy", 32'(bus.req_ready), 32'd0);
            chk("t3_hold_busy", 32'(busy), 32'd1);
            tick();
        end
        bus.rsp_ready = 2'b10;
        tick();
        chk("t3_release_busy", 32'(busy), 32'd0);
        chk("t3_release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t3_next_grant", 32'(bus.req_ready), 32'd1);
        // Withdraw r0 before any edge sees the grant
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        #1;
        chk("t3_withdraw_rdy", 32'(bus.req_ready), 32'd0);
        tick();
        chk("t3_withdraw_idle", 32'(busy), 32'd0);

        // Reset during EXEC
        bus.req_a[15:0] = 16'h0001; bus.req_b[15:0] = 16'h0002; bus.req_op[2:0] = 3'b000;
        bus.req_valid   = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        chk("t4_exec_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_alu_a", 32'(alu_a), 32'd0);
        chk("t4_rst_alu_b", 32'(alu_b), 32'd0);
        chk("t4_rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("t4_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t4_rst_result", bus.rsp_result, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("t4_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("t4_idle", 32'(busy), 32'd0);
        end

        // ALUControl passthrough on r1
        run_single(1, 16'h00ff, 16'h0f0f, 3'b010, 32'h0000_000f, 1'b0, "t6_and");
        run_single(1, 16'ha000, 16'h050a, 3'b011, 32'h0000_a50a, 1'b0, "t6_or");
        run_single(1, 16'h8000, 16'h0001, 3'b101, 32'h0000_0001, 1'b0, "t6_slt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
